kf6845_light_pen: RTL and testbench

KF6845_LIGHT_PEN -- requirements
Module: kf6845_light_pen

---
 rtl/kf6845_pkg.sv | 14 +
 rtl/kf6845_light_pen_if.sv | 20 ++
 rtl/kf6845_strobe_sync.sv | 50 +++++
 rtl/kf6845_light_pen.sv | 59 +++++
 tb/tb_kf6845_light_pen.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/kf6845_pkg.sv
// Shared widths and constants for the KF6845 light pen slice.
package kf6845_pkg;

  localparam int MA_WIDTH     = 14;
  localparam int LPEN_H_WIDTH = 6;
  localparam int DATA_WIDTH   = 8;

  localparam logic [DATA_WIDTH-1:0] RESET_VALUE = 8'h00;

  function automatic logic [DATA_WIDTH-1:0] lpen_h_byte(input logic [LPEN_H_WIDTH-1:0] h);
    return {{(DATA_WIDTH-LPEN_H_WIDTH){1'b0}}, h};
  endfunction

endpackage

// File: rtl/kf6845_light_pen_if.sv
// CPU-side register read port of the light pen block.
interface kf6845_light_pen_if;

  logic                              read_light_pen_h_register;
  logic                              read_light_pen_l_register;
  logic [kf6845_pkg::DATA_WIDTH-1:0] internal_data_bus_out;

  modport master (
    output read_light_pen_h_register,
    output read_light_pen_l_register,
    input  internal_data_bus_out
  );

  modport slave (
    input  read_light_pen_h_register,
    input  read_light_pen_l_register,
    output internal_data_bus_out
  );

endinterface

// File: rtl/kf6845_strobe_sync.sv
// Light pen strobe conditioning and rising-edge detection.
// Define KF6845_LPSTB_SYNC_EN to insert a 2-flop synchronizer ahead of the detector.
module kf6845_strobe_sync (
  input  logic clock,
  input  logic reset,
  input  logic async_in,
  output logic rise_pulse
);

  logic w_level;
  logic w_valid;
  logic r_prev;
  logic r_armed;

`ifdef KF6845_LPSTB_SYNC_EN
  logic [1:0] r_sync;
  logic [1:0] r_fill;

  // r_fill marks when the synchronizer holds real samples rather than reset zeros
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sync <= 2'b00;
      r_fill <= 2'b00;
    end else begin
      r_sync <= {r_sync[0], async_in};
      r_fill <= {r_fill[0], 1'b1};
    end
  end

  assign w_level = r_sync[1];
  assign w_valid = r_fill[1];
`else
  assign w_level = async_in;
  assign w_valid = 1'b1;
`endif

  // A strobe must be seen low after reset before any rise is honoured
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_prev  <= 1'b0;
      r_armed <= 1'b0;
    end else begin
      r_prev  <= w_level;
      r_armed <= r_armed | (w_valid & ~w_level);
    end
  end

  assign rise_pulse = w_level & ~r_prev & r_armed;

endmodule

// File: rtl/kf6845_light_pen.sv
// KF6845 CRTC light pen: captures MA into R16/R17 on a strobe and serves CPU reads.
// Optional macro KF6845_LPSTB_SYNC_EN enables the strobe synchronizer in kf6845_strobe_sync.
module kf6845_light_pen
  import kf6845_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  input  logic                video_clock_enable,
  input  logic                LPSTB,
  input  logic [MA_WIDTH-1:0] MA,
  kf6845_light_pen_if.slave   cpu
);

  logic                    w_rise;
  logic                    w_capture;
  logic                    r_pending;
  logic [LPEN_H_WIDTH-1:0] r_lpen_h;
  logic [DATA_WIDTH-1:0]   r_lpen_l;
  logic [DATA_WIDTH-1:0]   w_bus;

  kf6845_strobe_sync u_strobe_sync (
    .clock      (clock),
    .reset      (reset),
    .async_in   (LPSTB),
    .rise_pulse (w_rise)
  );

  // An edge coinciding with an enabled cycle captures immediately
  assign w_capture = video_clock_enable & (r_pending | w_rise);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_pending <= 1'b0;
      r_lpen_h  <= '0;
      r_lpen_l  <= RESET_VALUE;
    end else begin
      if (w_capture) begin
        r_pending <= 1'b0;
        r_lpen_h  <= MA[MA_WIDTH-1:DATA_WIDTH];
        r_lpen_l  <= MA[DATA_WIDTH-1:0];
      end else if (w_rise) begin
        r_pending <= 1'b1;
      end
    end
  end

  always_comb begin
    w_bus = RESET_VALUE;
    if (reset)
      w_bus = RESET_VALUE;
    else if (cpu.read_light_pen_h_register)
      w_bus = lpen_h_byte(r_lpen_h);
    else if (cpu.read_light_pen_l_register)
      w_bus = r_lpen_l;
  end

  assign cpu.internal_data_bus_out = w_bus;

endmodule

// File: tb/tb_kf6845_light_pen.sv
// Self-checking bench for kf6845_light_pen: directed scenarios plus randomized traffic vs a reference model.
module tb_kf6845_light_pen;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        video_clock_enable = 1'b0;
  logic        LPSTB = 1'b0;
  logic [13:0] MA = '0;

  int checks = 0;
  int errors = 0;

  // Reference state: the last captured address and whether a strobe is awaiting an enabled cycle
  logic [13:0] capturedMa = '0;
  bit          waitingForEnable = 0;
  bit          strobeWasHigh = 0;
  bit          seenLowSinceReset = 0;

  kf6845_light_pen_if cpu ();

  kf6845_light_pen dut (
    .clock              (clock),
    .reset              (reset),
    .video_clock_enable (video_clock_enable),
    .LPSTB              (LPSTB),
    .MA                 (MA),
    .cpu                (cpu)
  );

  always #5 clock = ~clock;

  function automatic logic [7:0] modelBus();
    if (reset) return 8'h00;
    if (cpu.read_light_pen_h_register) return {2'b00, capturedMa[13:8]};
    if (cpu.read_light_pen_l_register) return capturedMa[7:0];
    return 8'h00;
  endfunction

  task automatic checkOutput(input string tag, input logic [7:0] expected);
    checks++;
    assert (cpu.internal_data_bus_out === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed %h expected %h", tag, cpu.internal_data_bus_out, expected);
    end
  endtask

  task automatic applyStimulus(input bit lp, input bit vce, input logic [13:0] ma,
                               input bit rh, input bit rl);
    LPSTB = lp;
    video_clock_enable = vce;
    MA = ma;
    cpu.read_light_pen_h_register = rh;
    cpu.read_light_pen_l_register = rl;
    #1;
  endtask

  // Advance one clock, updating the reference with the inputs seen at that edge
  task automatic clockEdge();
    bit newStrobe;
    newStrobe = LPSTB && !strobeWasHigh && seenLowSinceReset;
    if (newStrobe) waitingForEnable = 1;
    if (waitingForEnable && video_clock_enable) begin
      capturedMa = MA;
      waitingForEnable = 0;
    end
    if (!LPSTB) seenLowSinceReset = 1;
    strobeWasHigh = LPSTB;
    @(posedge clock);
    #1;
  endtask

  task automatic pulseReset();
    reset = 1'b1;
    cpu.read_light_pen_h_register = 1'b1;
    cpu.read_light_pen_l_register = 1'b1;
    #1;
    checkOutput("bus_during_reset", 8'h00);
    capturedMa = '0;
    waitingForEnable = 0;
    strobeWasHigh = 0;
    seenLowSinceReset = 0;
    reset = 1'b0;
    cpu.read_light_pen_h_register = 1'b0;
    cpu.read_light_pen_l_register = 1'b0;
    #1;
  endtask

  task automatic readBoth(input string tag, input logic [7:0] expH, input logic [7:0] expL);
    cpu.read_light_pen_h_register = 1'b1;
    cpu.read_light_pen_l_register = 1'b0;
    #1;
    checkOutput({tag, "_H"}, expH);
    cpu.read_light_pen_h_register = 1'b0;
    cpu.read_light_pen_l_register = 1'b1;
    #1;
    checkOutput({tag, "_L"}, expL);
    cpu.read_light_pen_l_register = 1'b0;
  endtask

  task automatic cycle(input string tag, input bit lp, input bit vce, input logic [13:0] ma,
                       input bit rh, input bit rl);
    applyStimulus(lp, vce, ma, rh, rl);
    checkOutput(tag, modelBus());
    clockEdge();
  endtask

  initial begin
    bit lp;
    cpu.read_light_pen_h_register = 1'b0;
    cpu.read_light_pen_l_register = 1'b0;
    #3;
    pulseReset();
    @(posedge clock);
    #1;

    applyStimulus(0, 0, 14'h0000, 0, 0);
    checkOutput("reset_idle_bus", 8'h00);
    readBoth("reset_regs", 8'h00, 8'h00);
    clockEdge();

    // Pulse of two cycles with the enable toggling; read in the capture cycle sees the old value
    for (int i = 0; i < 6; i++)
      cycle("pulse3aa", (i == 2 || i == 3), i[0], 14'h03AA, 1, 0);
    readBoth("cap3aa", 8'h03, 8'hAA);

    // Held-high strobe must not recapture
    cycle("rise_hold", 0, 1, 14'h0123, 0, 0);
    cycle("rise_hold", 1, 1, 14'h03AA, 0, 0);
    for (int i = 0; i < 4; i++) cycle("hold_high", 1, 1, 14'h0123, 0, 1);
    readBoth("hold0123", 8'h03, 8'hAA);

    // Edge and enable on the same cycle
    cycle("low3fff", 0, 1, 14'h3FFF, 0, 0);
    cycle("low3fff", 0, 1, 14'h3FFF, 0, 0);
    cycle("edge3fff", 1, 1, 14'h3FFF, 1, 0);
    cycle("after3fff", 0, 0, 14'h0000, 0, 0);
    readBoth("cap3fff", 8'h3F, 8'hFF);
    applyStimulus(0, 0, 14'h0000, 1, 1);
    checkOutput("both_selects", 8'h3F);
    clockEdge();

    // A second edge while pending is absorbed into one capture
    cycle("absorb", 1, 0, 14'h1111, 0, 0);
    cycle("absorb", 0, 0, 14'h2222, 0, 0);
    cycle("absorb", 1, 0, 14'h3333, 0, 0);
    cycle("absorb", 1, 1, 14'h2A5C, 0, 0);
    cycle("absorb", 1, 1, 14'h0001, 0, 0);
    readBoth("absorb", 8'h2A, 8'h5C);

    // Reset discards a pending capture and requires the strobe to go low again
    cycle("pend1234", 0, 0, 14'h1234, 0, 0);
    cycle("pend1234", 1, 0, 14'h1234, 0, 0);
    pulseReset();
    for (int i = 0; i < 3; i++) cycle("post_reset_high", 1, 1, 14'h1234, 0, 0);
    readBoth("reset1234", 8'h00, 8'h00);
    cycle("rearm", 0, 1, 14'h0ABC, 0, 0);
    cycle("rearm", 1, 1, 14'h0ABC, 0, 0);
    readBoth("rearm0abc", 8'h0A, 8'hBC);

    // Randomized traffic against the reference
    lp = 0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0) pulseReset();
      if ($urandom_range(0, 3) == 0) lp = ~lp;
      cycle("random", lp, ($urandom_range(0, 2) == 0), 14'($urandom),
            $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
